kernel_seq_ctrl: RTL
====================

# kernel_seq_ctrl

Controller that owns the kernel weight buffer's write and read ports. It loads a KERNEL_SIZE×KERNEL_SIZE weight set from a valid/ready stream into the buffer. It then sequences read addresses for one convolution window per start request, with MAC enable and first/last markers. It sits between the weight-fetch stream and the kernel buffer/MAC datapath.

## Interface
- KERNEL_SIZE, 3, kernel edge length; the buffer holds N = KERNEL_SIZE*KERNEL_SIZE weights
- KERNEL_ADDR_WIDTH, 5, address width of the buffer ports; must satisfy 2^KERNEL_ADDR_WIDTH ≥ N
- WEIGHT_WIDTH, 8, weight bit width

Ports (reset is synchronous, active-high, single clock i_clk):
- i_clk  in  1  clock; everything is sampled on the rising edge
- i_rst  in  1  synchronous active-high reset
- load_start  in  1  pulse; requests loading of a new kernel
- w_valid  in  1  weight stream valid
- w_data  in  WEIGHT_WIDTH  weight stream data, row-major order
- w_ready  out  1  weight stream ready
- kr_wr_en  out  1  buffer write enable
- kr_wr_addr  out  KERNEL_ADDR_WIDTH  buffer write address
- kr_wr_data  out  WEIGHT_WIDTH  buffer write data
- win_start  in  1  pulse; requests one window pass
- win_ready  out  1  high when win_start will be accepted
- kr_rd_addr  out  KERNEL_ADDR_WIDTH  buffer read address
- mac_en  out  1  the weight at kr_rd_addr is valid this cycle
- mac_first  out  1  first tap of the window (address 0)
- mac_last  out  1  last tap of the window (address N-1)
- kernel_loaded  out  1  a complete kernel is resident
- load_done  out  1  one-cycle pulse when a load completes

## Operation
States: IDLE, LOAD, READY, RUN.

- **IDLE** (after reset)
  - kernel_loaded=0.
  - load_start → LOAD, wcnt=0.
  - win_start is ignored.
- **LOAD**
  - w_ready=1.
  - A transfer occurs when w_valid&w_ready: kr_wr_en=1, kr_wr_addr=wcnt, kr_wr_data=w_data, then wcnt++.
  - On the transfer with wcnt==N-1: → READY, load_done=1 for that cycle, kernel_loaded=1 from the next cycle.
  - kernel_loaded is forced to 0 on entry to LOAD.
  - load_start while in LOAD restarts wcnt at 0.
- **READY**
  - win_ready=1.
  - win_start → RUN, rcnt=0.
  - load_start → LOAD.
  - If both win_start and load_start are asserted, load_start wins and win_start is dropped.
- **RUN**
  - mac_en=1, kr_rd_addr=rcnt, mac_first=(rcnt==0), mac_last=(rcnt==N-1); rcnt++ each cycle.
  - After the rcnt==N-1 cycle: → READY.
  - win_start and load_start are ignored in RUN; requesters must wait for win_ready.
- The counters are KERNEL_ADDR_WIDTH wide. They never wrap past N-1; they reset to 0 on each state entry.
- kr_wr_addr and kr_wr_data are combinational from wcnt and w_data. kr_wr_en = w_valid & w_ready.

## Timing
- Reset values: all outputs 0 (w_ready, kr_wr_en, addresses, mac_*, win_ready, kernel_loaded, load_done). State=IDLE, counters=0.
- The buffer read is combinational, so kr_rd_data aligns with mac_en in the same cycle. The datapath adds no read latency.
- Load latency: N accepted beats. With w_valid held high, load_start at cycle t gives beats at t+1 … t+N and load_done at t+N.
- Window pass: win_start at cycle t gives mac_en high for cycles t+1 … t+N and win_ready high again at t+N+1. Back-to-back windows therefore have a gap of one idle cycle.
- w_valid low in LOAD stalls with no write. There is no timeout.
- i_rst mid-LOAD or mid-RUN:
  - Next state is IDLE and kernel_loaded=0.
  - Partially written buffer contents are left as-is but treated as invalid.
- Outputs w_ready, win_ready, mac_* and kernel_loaded are registered or decoded from state only. None depends combinationally on win_start or load_start.

## Test plan
- Reset, then load with continuous w_valid and data 0x10..0x18 (N=9):
  - kr_wr_addr 0..8 with matching data on 9 consecutive cycles.
  - load_done single pulse on the 9th beat; kernel_loaded=1 afterward.
- Load with w_valid toggling 1,0,1,0:
  - Writes occur only on valid cycles, addresses stay contiguous 0..8.
  - load_done follows the 9th accepted beat, on cycle 17.
- After load, win_start pulse:
  - mac_en high exactly 9 cycles, kr_rd_addr 0..8.
  - mac_first only with address 0, mac_last only with address 8.
  - win_ready is low during the pass and returns one cycle after the pass.
- win_start held high continuously: each pass is 9 mac_en cycles followed by 1 idle cycle. win_start asserted during RUN starts no extra pass.
- load_start and win_start in the same READY cycle: LOAD is entered, no mac_en, and kernel_loaded drops to 0 the next cycle.
- i_rst asserted after the 4th beat of a load:
  - Next cycle: all outputs 0 and state IDLE.
  - A following win_start produces no mac_en.
  - A new load restarts at address 0.

Source files
------------

// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl
// Owns the kernel weight buffer ports. A load request streams
// KERNEL_SIZE*KERNEL_SIZE weights (row-major) from a valid/ready source into
// the buffer. After that, each accepted window request walks the read address
// 0..N-1 once, with MAC enable and first/last tap markers.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   load_start                pulse: (re)load a kernel
//   w_valid, w_data, w_ready  weight stream, row-major
//   kr_wr_en/addr/data        buffer write port
//   win_start, win_ready      window pass request / acceptance
//   kr_rd_addr                buffer read address (combinational read)
//   mac_en/first/last         tap valid and window boundary markers
//   kernel_loaded             a complete kernel is resident
//   load_done                 one-cycle pulse on the final accepted beat
module kernel_seq_ctrl #(
  parameter int KERNEL_SIZE       = 3,
  parameter int KERNEL_ADDR_WIDTH = 5,
  parameter int WEIGHT_WIDTH      = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         load_start,
  input  logic                         w_valid,
  input  logic [WEIGHT_WIDTH-1:0]      w_data,
  output logic                         w_ready,
  output logic                         kr_wr_en,
  output logic [KERNEL_ADDR_WIDTH-1:0] kr_wr_addr,
  output logic [WEIGHT_WIDTH-1:0]      kr_wr_data,
  input  logic                         win_start,
  output logic                         win_ready,
  output logic [KERNEL_ADDR_WIDTH-1:0] kr_rd_addr,
  output logic                         mac_en,
  output logic                         mac_first,
  output logic                         mac_last,
  output logic                         kernel_loaded,
  output logic                         load_done
);

  localparam int N = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [KERNEL_ADDR_WIDTH-1:0] LAST = KERNEL_ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    RUN
  } state_t;

  state_t                       state;
  logic [KERNEL_ADDR_WIDTH-1:0] wcnt;
  logic [KERNEL_ADDR_WIDTH-1:0] rcnt;
  logic                         xfer;

  // Handshake-side outputs are pure state decodes so that neither request
  // input can reach them combinationally.
  assign w_ready    = (state == LOAD);
  assign win_ready  = (state == READY);
  assign mac_en     = (state == RUN);
  assign mac_first  = mac_en && (rcnt == '0);
  assign mac_last   = mac_en && (rcnt == LAST);
  assign kr_rd_addr = rcnt;

  assign xfer       = w_valid && w_ready;
  assign kr_wr_en   = xfer;
  assign kr_wr_addr = wcnt;
  // Write data is held at zero outside LOAD so the port is quiet when idle.
  assign kr_wr_data = w_ready ? w_data : '0;
  // A restart request on the final beat overrides completion.
  assign load_done  = xfer && (wcnt == LAST) && !load_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      wcnt          <= '0;
      rcnt          <= '0;
      kernel_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state         <= LOAD;
            wcnt          <= '0;
            kernel_loaded <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wcnt <= '0;
          end else if (xfer) begin
            if (wcnt == LAST) begin
              state         <= READY;
              wcnt          <= '0;
              kernel_loaded <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        READY: begin
          // Reload takes priority; a simultaneous window request is dropped.
          if (load_start) begin
            state         <= LOAD;
            wcnt          <= '0;
            kernel_loaded <= 1'b0;
          end else if (win_start) begin
            state <= RUN;
            rcnt  <= '0;
          end
        end
        RUN: begin
          if (rcnt == LAST) begin
            state <= READY;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
          rcnt  <= '0;
        end
      endcase
    end
  end

endmodule
